calc_entry_ctrl: RTL and testbench
==================================

Name: calc_entry_ctrl

Overview:
- Parametrised key-entry controller for the calculator; successor to the two-operand A/B entry FSM.
- Sequences NUM_OPERANDS operands and tracks a per-operand digit count with a MAX_DIGITS limit.
- Arbitrates simultaneous key pulses and adds clear, equals and an eval request/ack handshake toward the ALU.
- Sits between the key decoder (one-cycle key pulses) and the operand shift registers / ALU.

Parameters:
NUM_OPERANDS, 2, number of operand registers (>=2)
MAX_DIGITS, 4, max digits per operand (>=1)
(derived) IDX_W = max(1, clog2(NUM_OPERANDS)); CNT_W = clog2(MAX_DIGITS+1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
dig_in  in  1  digit key pulse
op_in  in  1  operator key pulse
bksp_in  in  1  backspace key pulse
eq_in  in  1  equals key pulse
clr_in  in  1  clear key pulse
eval_ack  in  1  ALU done; sampled while eval_req=1
load  out  NUM_OPERANDS  one-hot shift-in strobe to operand register
bksp  out  NUM_OPERANDS  one-hot shift-out strobe to operand register
clr_all  out  1  clear all operand registers
sel  out  IDX_W  current operand index
digit_cnt  out  CNT_W  digit count of operand sel
eval_req  out  1  ALU evaluation request
result_valid  out  1  ALU result is displayed
overflow  out  1  one-cycle pulse: digit rejected

Behaviour:
- Reset (async): state ENTRY, sel=0, all counts 0, eval_req=0, result_valid=0, overflow=0.
- load, bksp and clr_all are combinational from state and inputs, asserted in the same cycle as the accepted key. All other outputs are registered.
- States: ENTRY, SETTLE, EVAL, RESULT.
- Input priority when keys coincide: clr > eq > op > bksp > dig. Only the highest asserted key is acted on; the rest are dropped.
- ENTRY:
  - clr: clr_all=1; all counts 0; sel=0; stay in ENTRY.
  - eq: if sel==NUM_OPERANDS-1 and cnt[sel]>0, go to EVAL. Otherwise ignored.
  - op: sel increments, wrapping from NUM_OPERANDS-1 to 0. Counts are retained.
  - bksp: if cnt[sel]>0, bksp[sel]=1, cnt[sel]-1, go to SETTLE. If 0, no strobe and no change.
  - dig: if cnt[sel]<MAX_DIGITS, load[sel]=1, cnt[sel]+1, go to SETTLE. If full, overflow=1 on the next cycle, no load, stay in ENTRY.
- SETTLE: one-cycle lockout. All keys are ignored and no strobes are asserted. Returns to ENTRY.
- EVAL:
  - eval_req=1 from the cycle after entry and held until eval_ack is sampled high.
  - Then eval_req=0 and result_valid=1 on the next cycle; go to RESULT.
  - clr aborts: eval_req=0, clear as in ENTRY, go to ENTRY. All other keys are ignored.
  - eval_ack outside EVAL is ignored.
- RESULT (result_valid held at 1):
  - dig: clr_all=1 and load[0]=1 in the same cycle; cnt[0]=1, other counts 0, sel=0, result_valid=0; go to SETTLE.
  - op: chain. result_valid=0; sel=1; cnt[0]=MAX_DIGITS (the result is treated as full operand 0); other counts 0; go to ENTRY.
  - clr: as in ENTRY; result_valid=0.
  - eq and bksp are ignored.
- Counts saturate at 0 and MAX_DIGITS; they never wrap.
- digit_cnt always reflects cnt[sel].

Optional Feature:
CALC_AUTO_ADVANCE_EN
- Defined: a dig into a full operand with sel<NUM_OPERANDS-1 advances sel by 1 and loads that digit into the next operand in the same cycle (load[sel+1]=1, cnt[sel+1]+1, go to SETTLE). No overflow pulse. The last operand still overflows.
- Undefined: a full operand always rejects with an overflow pulse, as specified in Behaviour.

Decomposition:
- calc_pkg:
  - state enum typedef (ENTRY, SETTLE, EVAL, RESULT)
  - key-priority encoding typedef
  - IDX_W/CNT_W helper functions
- Sub-module calc_digit_counter:
  - saturating up/down counter with sync clear, instantiated once per operand via generate.
  - ports: clock, reset, inc, dec, clr, set_max, cnt, full, empty.

Test Plan:
(NUM_OPERANDS=2, MAX_DIGITS=4)
- Reset, then dig x3 spaced by 2 cycles -> three load[0] pulses, digit_cnt=3, sel=0. Back-to-back dig on consecutive cycles -> second pulse ignored (SETTLE).
- 5 digs on operand 0 -> 4 load pulses and 1 overflow pulse; digit_cnt=4. Repeat with CALC_AUTO_ADVANCE_EN -> 5th dig gives load[1], sel=1, no overflow.
- dig, bksp, bksp on operand 0 -> load, bksp[0], then no strobe; digit_cnt ends 0.
- op and dig asserted in the same cycle -> sel 0->1, no load. dig, op, dig, eq -> eval_req rises. Hold eval_ack low 5 cycles -> eval_req stays 1. Then ack -> result_valid=1.
- In RESULT: dig -> clr_all and load[0] in the same cycle, digit_cnt=1. From RESULT: op -> sel=1, result_valid=0.
- Assert reset mid-EVAL -> eval_req=0 immediately (async), state ENTRY, all counts 0. clr during EVAL -> eval_req=0 next cycle, clr_all pulse.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and width helpers for the calculator key-entry controller.
package calc_pkg;

    typedef enum logic [1:0] {
        StEntry,
        StSettle,
        StEval,
        StResult
    } state_e;

    typedef enum logic [2:0] {
        KeyNone,
        KeyDig,
        KeyBksp,
        KeyOp,
        KeyEq,
        KeyClr
    } key_e;

    function automatic int unsigned idx_width(input int unsigned n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned m);
        return $clog2(m + 1);
    endfunction

    // Coincident key pulses collapse to the single highest-priority key.
    function automatic key_e key_select(input logic clr, input logic eq, input logic op,
                                        input logic bksp, input logic dig);
        if (clr)  return KeyClr;
        if (eq)   return KeyEq;
        if (op)   return KeyOp;
        if (bksp) return KeyBksp;
        if (dig)  return KeyDig;
        return KeyNone;
    endfunction

endpackage

// File: rtl/calc_digit_counter.sv
// Per-operand digit counter: saturating up/down with synchronous clear and load-to-max.
module calc_digit_counter
    import calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned CNT_W      = cnt_width(MAX_DIGITS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             set_max,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign full  = (cnt_q == CNT_W'(MAX_DIGITS));
    assign empty = (cnt_q == '0);
    assign cnt   = cnt_q;

    // clr together with inc restarts the operand with a single digit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? CNT_W'(1) : '0;
        end else if (set_max) begin
            cnt_d = CNT_W'(MAX_DIGITS);
        end else if (inc && !full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !empty) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator key-entry controller: operand sequencing, digit counting and ALU eval handshake.
// Optional build macro CALC_AUTO_ADVANCE_EN: a digit into a full operand spills into the next one.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned NUM_OPERANDS = 2,
    parameter int unsigned MAX_DIGITS   = 4,
    localparam int unsigned IDX_W       = idx_width(NUM_OPERANDS),
    localparam int unsigned CNT_W       = cnt_width(MAX_DIGITS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    dig_in,
    input  logic                    op_in,
    input  logic                    bksp_in,
    input  logic                    eq_in,
    input  logic                    clr_in,
    input  logic                    eval_ack,
    output logic [NUM_OPERANDS-1:0] load,
    output logic [NUM_OPERANDS-1:0] bksp,
    output logic                    clr_all,
    output logic [IDX_W-1:0]        sel,
    output logic [CNT_W-1:0]        digit_cnt,
    output logic                    eval_req,
    output logic                    result_valid,
    output logic                    overflow
);

    localparam logic [IDX_W-1:0] LastSel = IDX_W'(NUM_OPERANDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             eval_req_q, eval_req_d;
    logic             result_valid_q, result_valid_d;
    logic             overflow_q, overflow_d;

    logic [NUM_OPERANDS-1:0] cnt_inc, cnt_dec, cnt_clr, cnt_set_max;
    logic [NUM_OPERANDS-1:0] full, empty;
    logic [CNT_W-1:0]        cnt_a [NUM_OPERANDS];
    key_e                    key;

    assign key = key_select(clr_in, eq_in, op_in, bksp_in, dig_in);

    for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_cnt
        calc_digit_counter #(
            .MAX_DIGITS(MAX_DIGITS),
            .CNT_W     (CNT_W)
        ) u_cnt (
            .clock  (clock),
            .reset  (reset),
            .inc    (cnt_inc[g]),
            .dec    (cnt_dec[g]),
            .clr    (cnt_clr[g]),
            .set_max(cnt_set_max[g]),
            .cnt    (cnt_a[g]),
            .full   (full[g]),
            .empty  (empty[g])
        );
    end

`ifdef CALC_AUTO_ADVANCE_EN
    logic [IDX_W-1:0] next_sel;
    assign next_sel = sel_q + IDX_W'(1);
`endif

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        eval_req_d     = eval_req_q;
        result_valid_d = result_valid_q;
        overflow_d     = 1'b0;
        load           = '0;
        bksp           = '0;
        clr_all        = 1'b0;
        cnt_inc        = '0;
        cnt_dec        = '0;
        cnt_clr        = '0;
        cnt_set_max    = '0;

        unique case (state_q)
            StEntry: begin
                unique case (key)
                    KeyClr: begin
                        clr_all = 1'b1;
                        cnt_clr = '1;
                        sel_d   = '0;
                    end
                    KeyEq: begin
                        if (sel_q == LastSel && !empty[sel_q]) state_d = StEval;
                    end
                    KeyOp: begin
                        sel_d = (sel_q == LastSel) ? '0 : sel_q + IDX_W'(1);
                    end
                    KeyBksp: begin
                        if (!empty[sel_q]) begin
                            bksp[sel_q]    = 1'b1;
                            cnt_dec[sel_q] = 1'b1;
                            state_d        = StSettle;
                        end
                    end
                    KeyDig: begin
                        if (!full[sel_q]) begin
                            load[sel_q]    = 1'b1;
                            cnt_inc[sel_q] = 1'b1;
                            state_d        = StSettle;
                        end else begin
`ifdef CALC_AUTO_ADVANCE_EN
                            if (sel_q != LastSel) begin
                                sel_d             = next_sel;
                                load[next_sel]    = 1'b1;
                                cnt_inc[next_sel] = 1'b1;
                                state_d           = StSettle;
                            end else begin
                                overflow_d = 1'b1;
                            end
`else
                            overflow_d = 1'b1;
`endif
                        end
                    end
                    default: ;
                endcase
            end
            StSettle: begin
                state_d = StEntry;
            end
            StEval: begin
                // Request rises one cycle after entering EVAL; ack only counts once it is up.
                if (key == KeyClr) begin
                    eval_req_d = 1'b0;
                    clr_all    = 1'b1;
                    cnt_clr    = '1;
                    sel_d      = '0;
                    state_d    = StEntry;
                end else if (eval_req_q && eval_ack) begin
                    eval_req_d     = 1'b0;
                    result_valid_d = 1'b1;
                    state_d        = StResult;
                end else begin
                    eval_req_d = 1'b1;
                end
            end
            StResult: begin
                unique case (key)
                    KeyClr: begin
                        clr_all        = 1'b1;
                        cnt_clr        = '1;
                        sel_d          = '0;
                        result_valid_d = 1'b0;
                        state_d        = StEntry;
                    end
                    KeyOp: begin
                        // Result becomes a full operand 0; entry continues on operand 1.
                        cnt_clr        = '1;
                        cnt_clr[0]     = 1'b0;
                        cnt_set_max[0] = 1'b1;
                        sel_d          = IDX_W'(1);
                        result_valid_d = 1'b0;
                        state_d        = StEntry;
                    end
                    KeyDig: begin
                        clr_all        = 1'b1;
                        load[0]        = 1'b1;
                        cnt_clr        = '1;
                        cnt_inc[0]     = 1'b1;
                        sel_d          = '0;
                        result_valid_d = 1'b0;
                        state_d        = StSettle;
                    end
                    default: ;
                endcase
            end
            default: state_d = StEntry;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StEntry;
            sel_q          <= '0;
            eval_req_q     <= 1'b0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            eval_req_q     <= eval_req_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    assign sel          = sel_q;
    assign digit_cnt    = cnt_a[sel_q];
    assign eval_req     = eval_req_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Scoreboard bench for calc_entry_ctrl (NUM_OPERANDS=2, MAX_DIGITS=4) against a behavioural model.
module tb_calc_entry_ctrl;

    localparam int N = 2;
    localparam int M = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dig_in = 0, op_in = 0, bksp_in = 0, eq_in = 0, clr_in = 0, eval_ack = 0;
    logic [1:0] load, bksp;
    logic       clr_all;
    logic [0:0] sel;
    logic [2:0] digit_cnt;
    logic       eval_req, result_valid, overflow;

    calc_entry_ctrl #(
        .NUM_OPERANDS(N),
        .MAX_DIGITS  (M)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .dig_in      (dig_in),
        .op_in       (op_in),
        .bksp_in     (bksp_in),
        .eq_in       (eq_in),
        .clr_in      (clr_in),
        .eval_ack    (eval_ack),
        .load        (load),
        .bksp        (bksp),
        .clr_all     (clr_all),
        .sel         (sel),
        .digit_cnt   (digit_cnt),
        .eval_req    (eval_req),
        .result_valid(result_valid),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ld, bk, ca, sl, dc, rq, rv, ov;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: mode 0 entry, 1 lockout, 2 evaluating, 3 showing result.
    int m_mode, m_sel;
    int m_cnt[N];
    int m_req, m_rv, m_ovf;

    task automatic model_reset();
        m_mode = 0; m_sel = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        m_req = 0; m_rv = 0; m_ovf = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_all_ops(inout exp_t r);
        r.ca = 1; m_cnt[0] = 0; m_cnt[1] = 0; m_sel = 0;
    endtask

    // One cycle: drive keys just after the rising edge, predict and queue the response.
    task automatic step(input bit d, input bit o, input bit b, input bit e, input bit c,
                        input bit a);
        exp_t r;
        int   novf;
        @(posedge clock);
        #1;
        dig_in = d; op_in = o; bksp_in = b; eq_in = e; clr_in = c; eval_ack = a;
        r.ld = 0; r.bk = 0; r.ca = 0;
        r.sl = m_sel; r.dc = m_cnt[m_sel]; r.rq = m_req; r.rv = m_rv; r.ov = m_ovf;
        novf = 0;
        case (m_mode)
            0: begin
                if (c) clear_all_ops(r);
                else if (e) begin
                    if (m_sel == N - 1 && m_cnt[m_sel] > 0) m_mode = 2;
                end else if (o) m_sel = (m_sel + 1) % N;
                else if (b) begin
                    if (m_cnt[m_sel] > 0) begin
                        r.bk = 1 << m_sel; m_cnt[m_sel]--; m_mode = 1;
                    end
                end else if (d) begin
                    if (m_cnt[m_sel] < M) begin
                        r.ld = 1 << m_sel; m_cnt[m_sel]++; m_mode = 1;
                    end
`ifdef CALC_AUTO_ADVANCE_EN
                    else if (m_sel < N - 1) begin
                        m_sel++; r.ld = 1 << m_sel;
                        if (m_cnt[m_sel] < M) m_cnt[m_sel]++;
                        m_mode = 1;
                    end
`endif
                    else novf = 1;
                end
            end
            1: m_mode = 0;
            2: begin
                if (c) begin
                    clear_all_ops(r); m_req = 0; m_mode = 0;
                end else if (m_req == 1 && a) begin
                    m_req = 0; m_rv = 1; m_mode = 3;
                end else m_req = 1;
            end
            default: begin
                if (c) begin
                    clear_all_ops(r); m_rv = 0; m_mode = 0;
                end else if (e) begin
                end else if (o) begin
                    m_rv = 0; m_sel = 1; m_cnt[0] = M; m_cnt[1] = 0; m_mode = 0;
                end else if (b) begin
                end else if (d) begin
                    r.ca = 1; r.ld = 1; m_cnt[0] = 1; m_cnt[1] = 0; m_sel = 0;
                    m_rv = 0; m_mode = 1;
                end
            end
        endcase
        m_ovf = novf;
        q.push_back(r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents strobes and registered outputs at the falling edge.
    initial begin
        exp_t r;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                r = q.pop_front();
                chk("load", int'(load), r.ld);
                chk("bksp", int'(bksp), r.bk);
                chk("clr_all", int'(clr_all), r.ca);
                chk("sel", int'(sel), r.sl);
                chk("digit_cnt", int'(digit_cnt), r.dc);
                chk("eval_req", int'(eval_req), r.rq);
                chk("result_valid", int'(result_valid), r.rv);
                chk("overflow", int'(overflow), r.ov);
            end
        end
    end

    task automatic async_reset_check();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("async_eval_req", int'(eval_req), 0);
        chk("async_sel", int'(sel), 0);
        chk("async_digit_cnt", int'(digit_cnt), 0);
        chk("async_result_valid", int'(result_valid), 0);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle(1);

        // Spaced digits, then back-to-back, then into a full operand.
        for (int i = 0; i < 3; i++) begin step(1, 0, 0, 0, 0, 0); idle(1); end
        step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); idle(1);
        step(1, 0, 0, 0, 0, 0); idle(1);
        step(1, 0, 0, 0, 0, 0); idle(1);

        // Backspace down to empty and once more.
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0); idle(1);
        step(0, 0, 1, 0, 0, 0); idle(1);

        // op beats dig; then a full eval with a slow ack.
        step(1, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0); idle(1); step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0); idle(1); step(0, 0, 0, 1, 0, 0);
        idle(7); step(0, 0, 0, 0, 0, 1); idle(2);
        step(1, 0, 0, 0, 0, 0); idle(1);

        // Chain from a result via op.
        step(0, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); idle(1); step(0, 0, 0, 1, 0, 0);
        idle(3); step(0, 0, 0, 0, 0, 1); idle(2);
        step(0, 1, 0, 0, 0, 0); idle(1);

        // Async reset while evaluating, then clr abort.
        step(1, 0, 0, 0, 0, 0); idle(1); step(0, 0, 0, 1, 0, 0); idle(3);
        async_reset_check();
        idle(1);
        step(1, 0, 0, 0, 0, 0); idle(1); step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0); idle(1); step(0, 0, 0, 1, 0, 0); idle(3);
        step(0, 0, 0, 0, 1, 0); idle(2);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0);
        end
        idle(1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
        #2;
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
